// File: rtl/w_bit_serializer_pkg.sv
// serializer_defs: shared definitions for the w-bit serializer and its benches.
//   state_t           : serializer FSM state encoding (2'd3 is unused and
//                       recovers to ST_IDLE)
//   CLOCK_HALF_PERIOD : half clock period, in time units, for benches
package serializer_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int CLOCK_HALF_PERIOD = 5;

endpackage

// File: rtl/w_bit_serializer_piso.sv
// shift_reg_piso: loadable parallel-in / serial-out register with a registered
// serial output.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture din; its first bit appears on sout next cycle
//   shift    : advance one bit; load has priority
//   din      : parallel word
//   sout     : current serial bit (IDLE_W once the word is exhausted)
module shift_reg_piso
    import serializer_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_W    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] data;

    function automatic logic head(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return v[WIDTH-1];
        else           return v[0];
    endfunction

    // Vacated positions fill with IDLE_W, so one shift past the last bit
    // leaves sout at the idle level without any extra control.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return {v[WIDTH-2:0], IDLE_W};
        else           return {IDLE_W, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= {WIDTH{IDLE_W}};
            sout <= IDLE_W;
        end else if (load) begin
            sout <= head(din);
            data <= advance(din);
        end else if (shift) begin
            sout <= head(data);
            data <= advance(data);
        end
    end

endmodule

// File: rtl/w_bit_serializer.sv
// w_bit_serializer: parallel-to-serial front end for the sequence detector's
// w input. Words arrive over valid/ready and leave one bit per clock on w,
// qualified by w_valid, with GAP idle cycles (w = IDLE_W) between words.
//   Clock, Reset : clock, asynchronous active-high reset
//   in_data      : word to serialize (sampled only on acceptance)
//   in_valid     : in_data is valid
//   in_ready     : a word can be taken this cycle (registered)
//   w, w_valid   : serial bit and its qualifier
//   busy         : high in SHIFT or GAP
//   word_done    : high while the last bit of a word is on w
module w_bit_serializer
    import serializer_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_W    = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]     GAP_INIT = 4'(GAP);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_nxt;
    logic [3:0]    gap_cnt;
    logic          accept;
    logic          shift_en;

    assign accept   = in_valid & in_ready;
    assign bit_nxt  = bit_cnt + CW'(1);
    // The shift on the last bit pushes the idle fill onto w; a new load wins.
    assign shift_en = (state == ST_SHIFT) & ~accept;

    shift_reg_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .IDLE_W    (IDLE_W)
    ) u_piso (
        .clk   (Clock),
        .rst   (Reset),
        .load  (accept),
        .shift (shift_en),
        .din   (in_data),
        .sout  (w)
    );

    // in_ready is registered, so it is computed one cycle ahead: it rises for
    // the last bit (GAP==0) or for the final gap cycle, which keeps streamed
    // words exactly WIDTH+GAP cycles apart.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
            in_ready  <= 1'b1;
        end else if (accept) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            w_valid   <= 1'b1;
            busy      <= 1'b1;
            word_done <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    w_valid   <= 1'b0;
                    busy      <= 1'b0;
                    word_done <= 1'b0;
                    in_ready  <= 1'b1;
                end
                ST_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt   <= '0;
                        w_valid   <= 1'b0;
                        word_done <= 1'b0;
                        if (GAP > 0) begin
                            state    <= ST_GAP;
                            gap_cnt  <= GAP_INIT;
                            busy     <= 1'b1;
                            in_ready <= (GAP == 1);
                        end else begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        bit_cnt   <= bit_nxt;
                        word_done <= (bit_nxt == LAST_BIT);
                        in_ready  <= (GAP == 0) && (bit_nxt == LAST_BIT);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        state    <= ST_IDLE;
                        gap_cnt  <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        gap_cnt  <= gap_cnt - 4'd1;
                        in_ready <= (gap_cnt == 4'd2);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bit_cnt   <= '0;
                    gap_cnt   <= '0;
                    w_valid   <= 1'b0;
                    busy      <= 1'b0;
                    word_done <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
